// File: rtl/bsh_pkg.sv
// Shared constants and request bundle type for the barrel-shift arbiter slice.
package bsh_pkg;

  localparam int BSH_W    = 32;
  localparam int BSH_SH_W = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic [BSH_W-1:0]    data;
    logic                dir;
    logic [BSH_SH_W-1:0] sh;
  } bsh_req_t;

endpackage

// File: rtl/bsh_rot_core.sv
// Combinational 32-bit rotator: five log stages (1, 2, 4, 8, 16) with direction select.
module bsh_rot_core
  import bsh_pkg::*;
(
  input  logic [BSH_W-1:0]    data,
  input  logic                dir,
  input  logic [BSH_SH_W-1:0] sh,
  output logic [BSH_W-1:0]    result
);

  logic [BSH_W-1:0] x;

  // Each stage rotates by a fixed power of two; the loop unrolls into five mux layers.
  always_comb begin
    x = data;
    for (int unsigned i = 0; i < BSH_SH_W; i++) begin
      if (sh[i]) begin
        if (dir == DIR_RIGHT)
          x = (x >> (1 << i)) | (x << (BSH_W - (1 << i)));
        else
          x = (x << (1 << i)) | (x >> (BSH_W - (1 << i)));
      end
    end
    result = x;
  end

endmodule

// File: rtl/bsh_arb.sv
// Round-robin arbiter sharing one barrel rotator between N_REQ requesters,
// with a registered valid/ready response port and a saturating op counter.
module bsh_arb
  import bsh_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*BSH_W-1:0]    req_data,
  input  logic [N_REQ-1:0]          req_dir,
  input  logic [N_REQ*BSH_SH_W-1:0] req_sh,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [BSH_W-1:0]          rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic [15:0]               op_cnt
);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  next_ptr;
  logic [N_REQ-1:0] grant;
  logic             found;
  logic             out_free;
  logic             accept;
  int unsigned      idx;
  bsh_req_t         reqs [N_REQ];
  bsh_req_t         sel;
  logic [BSH_W-1:0] rot;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign reqs[g] = '{data: req_data[BSH_W*g +: BSH_W],
                       dir:  req_dir[g],
                       sh:   req_sh[BSH_SH_W*g +: BSH_SH_W]};
  end

  // Priority scan starting at rr_ptr, wrapping modulo N_REQ; first hit wins.
  always_comb begin
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = (32'(rr_ptr) + off) % N_REQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) grant[grant_id] = 1'b1;
  end

  assign out_free  = !rsp_valid || rsp_ready;
  assign accept    = rst_n && out_free && found;
  assign req_ready = accept ? grant : '0;
  assign sel       = reqs[grant_id];
  assign next_ptr  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  bsh_rot_core u_rot (
    .data   (sel.data),
    .dir    (sel.dir),
    .sh     (sel.sh),
    .result (rot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
      op_cnt    <= '0;
    end else begin
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_data  <= rot;
        rsp_id    <= grant_id;
        rr_ptr    <= next_ptr;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_valid && rsp_ready && op_cnt != '1)
        op_cnt <= op_cnt + 16'd1;
    end
  end

endmodule

// File: doc/bsh_arb.md
# bsh_arb

Round-robin arbiter and sequencer that shares one 32-bit barrel rotator between `N_REQ` independent requesters. Each requester presents an operand, a direction and a shift amount over a valid/ready handshake. The block grants one requester per cycle, rotates the operand through a single combinational rotator core, and registers the result on a single valid/ready response port tagged with the requester index. It sits between the per-unit issue logic and the shared shift resource, and also keeps a saturating count of completed operations.

## Interface
- `N_REQ`, 4: number of requesters; legal range 2..8.
- `ID_W`, 2: width of the requester index; equals clog2(`N_REQ`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req_valid` input `N_REQ`: per-requester operation valid.
- `req_ready` output `N_REQ`: per-requester accept; at most one bit high in any cycle.
- `req_data` input `N_REQ*32`: operands; requester i uses bits [32i+31:32i].
- `req_dir` input `N_REQ`: 1 = rotate right, 0 = rotate left.
- `req_sh` input `N_REQ*5`: rotate amounts 0..31; requester i uses bits [5i+4:5i].
- `rsp_valid` output 1: a result is held in the response register.
- `rsp_ready` input 1: downstream accepts the result.
- `rsp_data` output 32: rotated result.
- `rsp_id` output `ID_W`: index of the requester that produced `rsp_data`.
- `op_cnt` output 16: completed operations (response handshakes); saturates at 0xFFFF.

## Operation
- `out_free` = !`rsp_valid` || `rsp_ready`.
- Grant: first asserted `req_valid` bit found searching upward from `rr_ptr`, wrapping modulo `N_REQ`. The grant is purely combinational from `req_valid` and `rr_ptr`.
- `req_ready[i]` = `out_free` && grant[i]. A request is accepted when `req_valid[i]` && `req_ready[i]`.
- On accept:
  - `rsp_data` <= rotate(`req_data[i]`, `req_dir[i]`, `req_sh[i]`).
  - `rsp_id` <= i.
  - `rsp_valid` <= 1.
  - `rr_ptr` <= (i+1) mod `N_REQ`.
- No accept and `rsp_ready` high: `rsp_valid` <= 0. `rsp_data`, `rsp_id` and `rr_ptr` hold.
- Response register states:
  - EMPTY (`rsp_valid`=0): goes to FULL on accept.
  - FULL: with `rsp_ready`=0, stays FULL and holds `rsp_data` and `rsp_id` stable.
  - FULL: with `rsp_ready`=1, reloads on a same-cycle accept, otherwise goes to EMPTY.
- Rotation rules:
  - Left: result[k] = data[(k - sh) mod 32].
  - Right: result[k] = data[(k + sh) mod 32].
  - sh = 0 passes the operand unchanged.
  - sh = 16 gives the same result in both directions.
- `op_cnt` increments on each `rsp_valid` && `rsp_ready` cycle and holds at 0xFFFF.
- `rr_ptr` changes only on accept. Idle cycles do not rotate priority.
- Requesters must hold `req_data`, `req_dir` and `req_sh` stable while `req_valid` is high and the request has not been accepted. The block does not check this.

## Timing
- Latency: accept in cycle t, result visible on `rsp_data` with `rsp_valid`=1 in cycle t+1.
- Throughput: one operation per cycle while `rsp_ready` stays high. There are no bubbles between back-to-back accepts.
- Back-pressure: `rsp_ready`=0 with `rsp_valid`=1 forces all `req_ready` bits to 0 in the same cycle.
- Simultaneous response handshake and accept in the same cycle:
  - New data loads.
  - `rsp_valid` stays 1.
  - `op_cnt` counts the departing result.
- Reset, applied on any edge with `rst_n`=0 regardless of in-flight state:
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rr_ptr`=0, `op_cnt`=0.
  - `req_ready`=0 during reset.
  - An in-flight result is discarded and not counted.
- `req_ready` is a combinational function of `req_valid`, `rr_ptr`, `rsp_valid` and `rsp_ready`. There is no combinational path from `req_data` to any output.

## Structure
- Shared package `bsh_pkg`:
  - Constant `BSH_W` = 32.
  - Constant `BSH_SH_W` = 5.
  - Constant `DIR_LEFT` = 0.
  - Constant `DIR_RIGHT` = 1.
  - Typedef for the request bundle {data, dir, sh}.
- Sub-module `bsh_rot_core`: a combinational 32-bit rotator with 5 log stages (1, 2, 4, 8, 16) and a direction select. It is instantiated once, behind the grant mux.
- The round-robin search stays inline as a priority scan over the rotated `req_valid` vector.

## Test plan
- Rotate right, single requester: req 0 sends data=0x00000001, dir=1, sh=1 -> one cycle later rsp_data=0x80000000, rsp_id=0, op_cnt=1 after the handshake.
- Rotate left and half swap:
  - 0x80000000, dir=0, sh=1 -> 0x00000001.
  - 0x12345678, sh=16, either dir -> 0x56781234.
  - sh=0 -> the operand unchanged.
- Round robin: all 4 `req_valid` held high, `rsp_ready`=1 -> `rsp_id` sequence 0,1,2,3,0,1 with `rsp_valid` high every cycle after the first.
- Back-pressure:
  - Hold `rsp_ready`=0 for 3 cycles with a result pending -> `rsp_data` and `rsp_id` stable, all `req_ready`=0, `rr_ptr` unchanged.
  - Raise `rsp_ready` -> the next grant is taken in the same cycle.
- Sparse requests: only req 2 and req 0 valid, `rr_ptr`=1 -> req 2 granted first, then req 0; `rr_ptr` ends at 1.
- Reset mid-operation: assert `rst_n`=0 with `rsp_valid`=1 and `op_cnt`=5 -> next edge gives `rsp_valid`=0, `op_cnt`=0, `rr_ptr`=0; the first grant after release goes to the lowest valid index.
